// File: rtl/fir_disp_pkg.sv
// Shared types and helpers for the FIR result display: converter states and
// active-low 7-segment decode ({dp,g,f,e,d,c,b,a}).
package fir_disp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int BCD_W = 16;
  localparam int BIN_W = 12;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_bin2bcd_seq.sv
// Sequential double-dabble: 12-bit binary to 4-digit BCD, one shift per clock.
// o_bcd is the display register, updated in the DONE cycle.
module seg_bin2bcd_seq
  import fir_disp_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_done,
  output logic             o_busy
);

  conv_state_e state;
  logic [3:0] bit_cnt;
  logic [BCD_W+BIN_W-1:0] shreg;

  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            o_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'(BIN_W - 1)) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        DONE: begin
          o_bcd  <= shreg[BIN_W +: BCD_W];
          o_done <= 1'b0;
          if (i_start) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: load on accept, otherwise adjust-then-shift while converting
  always_ff @(posedge i_clk) begin
    if ((state == IDLE || state == DONE) && i_start)
      shreg <= {{BCD_W{1'b0}}, i_bin};
    else if (state == SHIFT)
      shreg <= {dabble_adj(shreg[BIN_W +: BCD_W]), shreg[BIN_W-1:0]} << 1;
  end

endmodule

// File: rtl/fir_result_display.sv
// FIR result display: pending-strobe capture, BCD conversion and multiplexed
// 7-segment scan. Define FIR_DISP_LZB_EN for leading-zero blanking.
module fir_result_display
  import fir_disp_pkg::*;
#(
  parameter int F_CLK   = 50000000,
  parameter int F_SCAN  = 1000,
  parameter int NUM_DIG = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [BIN_W-1:0] i_value,
  input  logic             i_valid,
  output logic             o_busy,
  output logic [7:0]       o_cs,
  output logic [7:0]       o_dig_sel
);

  localparam int TICK_N = F_CLK / F_SCAN;
  localparam int TICK_W = $clog2(TICK_N);

  logic             conv_busy, conv_done, conv_start, take_new;
  logic [BIN_W-1:0] start_bin, pend_val;
  logic             pend_flag;
  logic [BCD_W-1:0] disp_bcd;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick_wrap;
  logic [2:0]        ptr, ptr_nxt;
  logic [4:0]        lz_run;
  logic [3:0]        nib_nxt;
  logic [7:0]        seg_nxt;

  assign o_busy = conv_busy;

  // An idle converter takes a fresh strobe directly; otherwise pending feeds it
  always_comb begin
    take_new   = i_valid && !conv_busy;
    conv_start = take_new || (pend_flag && (!conv_busy || conv_done));
    start_bin  = take_new ? i_value : pend_val;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        pend_flag <= 1'b0;
    else if (take_new)   pend_flag <= 1'b0;
    else if (conv_start) pend_flag <= i_valid;
    else if (i_valid)    pend_flag <= 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_valid && conv_busy) pend_val <= i_value;
  end

  seg_bin2bcd_seq u_bcd (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(conv_start),
    .i_bin  (start_bin),
    .o_bcd  (disp_bcd),
    .o_done (conv_done),
    .o_busy (conv_busy)
  );

  // Scan: select and segments are both derived from the next pointer so they move together
  always_comb begin
    tick_wrap = (tick_cnt == TICK_W'(TICK_N - 1));
    ptr_nxt   = ptr;
    if (tick_wrap) ptr_nxt = (ptr == 3'(NUM_DIG - 1)) ? 3'd0 : ptr + 3'd1;

    lz_run[4] = 1'b1;
    for (int k = 3; k >= 0; k--) lz_run[k] = lz_run[k+1] && (disp_bcd[4*k +: 4] == 4'd0);

    nib_nxt = disp_bcd[{ptr_nxt[1:0], 2'b00} +: 4];
    seg_nxt = seg_decode(nib_nxt);
    if (ptr_nxt[2]) seg_nxt = SEG_BLANK;
`ifdef FIR_DISP_LZB_EN
    else if (ptr_nxt[1:0] != 2'd0 && lz_run[ptr_nxt[1:0]]) seg_nxt = SEG_BLANK;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt  <= '0;
      ptr       <= '0;
      o_cs      <= 8'hFF;
      o_dig_sel <= SEG_BLANK;
    end else begin
      tick_cnt  <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
      ptr       <= ptr_nxt;
      o_cs      <= ~(8'h01 << ptr_nxt);
      o_dig_sel <= seg_nxt;
    end
  end

endmodule
